// File: rtl/fas_freq_analyzer.sv
// fas_freq_analyzer: post-FFT peak finder.
// Captures a 16-bin complex frame, scans one bin per cycle computing
// re^2 + im^2, and reports the strongest bin (lowest index on ties)
// with a one-cycle done pulse sixteen cycles after capture.
//
// Handshake: fft_valid is a one-cycle strobe with no ready/backpressure.
// A frame is taken only in IDLE or on the final scan edge (idx = 15);
// a strobe on any other scan edge is dropped and flagged by an overrun pulse.
module fas_freq_analyzer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] peak_mag,
  output logic        busy,
  output logic        overrun
);

  localparam int NBINS = 16;
  localparam int DW    = 16;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [31:0] max_q;
  logic [3:0]  arg_q;
  logic [3:0]  freq_q;
  logic [31:0] peak_q;
  logic        done_q;
  logic        overrun_q;
  logic [31:0] frame_q [NBINS];

  logic [31:0] frame_in [NBINS];
  logic        capture;

  logic [31:0]          word_d;
  logic signed [DW-1:0] re_d;
  logic signed [DW-1:0] im_d;
  logic signed [31:0]   re_sq_d;
  logic signed [31:0]   im_sq_d;
  logic [31:0]          mag_d;
  logic [31:0]          max_d;
  logic [3:0]           arg_d;

  assign frame_in = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                      fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  // A new frame is accepted when idle or when the last bin is being scanned.
  assign capture = fft_valid && ((state_q == IDLE) || (idx_q == 4'd15));

  // Frame buffer: loaded on capture; the final-edge compare still sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      frame_q <= frame_in;
    end
  end

  // Magnitude of the current bin and the running argmax including it.
  always_comb begin
    word_d  = frame_q[idx_q];
    re_d    = $signed(word_d[31:16]);
    im_d    = $signed(word_d[15:0]);
    re_sq_d = 32'(re_d) * 32'(re_d);
    im_sq_d = 32'(im_d) * 32'(im_d);
    // Each square is at most 2^30, so the unsigned sum cannot exceed 2^31.
    mag_d   = $unsigned(re_sq_d) + $unsigned(im_sq_d);
    max_d   = max_q;
    arg_d   = arg_q;
    if (mag_d > max_q) begin
      max_d = mag_d;
      arg_d = idx_q;
    end
  end

  // Control FSM with registered result and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      max_q     <= 32'd0;
      arg_q     <= 4'd0;
      freq_q    <= 4'd0;
      peak_q    <= 32'd0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fft_valid) begin
            state_q <= SCAN;
            idx_q   <= 4'd0;
            max_q   <= 32'd0;
            arg_q   <= 4'd0;
          end
        end
        SCAN: begin
          if (idx_q == 4'd15) begin
            freq_q <= arg_d;
            peak_q <= max_d;
            done_q <= 1'b1;
            idx_q  <= 4'd0;
            max_q  <= 32'd0;
            arg_q  <= 4'd0;
            if (!fft_valid) begin
              state_q <= IDLE;
            end
          end else begin
            max_q     <= max_d;
            arg_q     <= arg_d;
            idx_q     <= idx_q + 4'd1;
            overrun_q <= fft_valid;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == SCAN);

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// tb_fas_freq_analyzer: directed table-driven bench for fas_freq_analyzer.
module tb_fas_freq_analyzer;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        busy;
  logic        overrun;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] bg;
    logic [3:0]  pbin;
    logic [31:0] pword;
    logic [3:0]  tbin;
    logic [31:0] tword;
    logic [3:0]  exp_freq;
    logic [31:0] exp_peak;
  } vec_t;

  vec_t vecs [7];

  fas_freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag), .busy(busy), .overrun(overrun)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_frame(input int v);
    for (int i = 0; i < 16; i++) d[i] = vecs[v].bg;
    d[vecs[v].tbin] = vecs[v].tword;
    d[vecs[v].pbin] = vecs[v].pword;
  endtask

  // Capture vector v, optionally strobe vector ovr_v at scan edge ovr_at (0 = never),
  // and check the full 16-cycle scan plus the result. Entered and left at a negedge.
  task automatic run_vector(input int v, input int ovr_v, input int ovr_at);
    @(negedge clk);
    load_frame(v);
    fft_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fft_valid = 1'b0;
    check($sformatf("v%0d busy_after_capture", v), 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      if (k == ovr_at) begin
        load_frame(ovr_v);
        fft_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      fft_valid = 1'b0;
      if (done !== (k == 16))
        check($sformatf("v%0d done_k%0d", v, k), 32'(done), 32'(k == 16));
      if (overrun !== (k == ovr_at))
        check($sformatf("v%0d overrun_k%0d", v, k), 32'(overrun), 32'(k == ovr_at));
    end
    checks += 2;
    check($sformatf("v%0d done_at_16", v), 32'(done), 32'd1);
    check($sformatf("v%0d freq", v), 32'(freq), 32'(vecs[v].exp_freq));
    check($sformatf("v%0d peak_mag", v), peak_mag, vecs[v].exp_peak);
    check($sformatf("v%0d busy_after_done", v), 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d done_pulse_end", v), 32'(done), 32'd0);
    check($sformatf("v%0d freq_hold", v), 32'(freq), 32'(vecs[v].exp_freq));
  endtask

  initial begin
    int bb [4];
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = 32'd0;

    //          bg            pbin   pword          tbin   tword          freq   peak
    vecs[0] = '{32'h0001_0001, 4'd0,  32'h0A00_0000, 4'd0,  32'h0A00_0000, 4'd0,  32'h0064_0000};
    vecs[1] = '{32'h7FFF_0000, 4'd9,  32'h8000_8000, 4'd9,  32'h8000_8000, 4'd9,  32'h8000_0000};
    vecs[2] = '{32'h0000_0000, 4'd3,  32'h0100_FF00, 4'd12, 32'h0100_FF00, 4'd3,  32'h0002_0000};
    vecs[3] = '{32'h0000_0000, 4'd0,  32'h0000_0000, 4'd0,  32'h0000_0000, 4'd0,  32'h0000_0000};
    vecs[4] = '{32'h0001_0000, 4'd15, 32'h0000_0002, 4'd15, 32'h0000_0002, 4'd15, 32'h0000_0004};
    vecs[5] = '{32'hFFFF_FFFF, 4'd7,  32'hFFF0_0003, 4'd7,  32'hFFF0_0003, 4'd7,  32'h0000_0109};
    vecs[6] = '{32'h0001_0001, 4'd1,  32'h0000_FFFE, 4'd1,  32'h0000_FFFE, 4'd1,  32'h0000_0004};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset done", 32'(done), 32'd0);
    check("reset freq", 32'(freq), 32'd0);
    check("reset peak_mag", peak_mag, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);

    // Table-driven single frames
    for (int v = 0; v < 7; v++) begin
      run_vector(v, 0, 0);
    end

    // Back-to-back frames every 16 cycles, peaks at 15, 1, 7, 0
    bb = '{4, 6, 5, 0};
    for (int f = 0; f < 4; f++) begin
      load_frame(bb[f]);
      fft_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fft_valid = 1'b0;
      check($sformatf("b2b%0d busy", f), 32'(busy), 32'd1);
      if (f > 0) begin
        check($sformatf("b2b%0d done", f - 1), 32'(done), 32'd1);
        check($sformatf("b2b%0d freq", f - 1), 32'(freq), 32'(vecs[bb[f-1]].exp_freq));
      end
      check($sformatf("b2b%0d overrun_at_capture", f), 32'(overrun), 32'd0);
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (done !== 1'b0 || overrun !== 1'b0)
          check($sformatf("b2b%0d quiet_k%0d", f, k), {30'd0, done, overrun}, 32'd0);
      end
      checks++;
    end
    @(posedge clk);
    @(negedge clk);
    check("b2b3 done", 32'(done), 32'd1);
    check("b2b3 freq", 32'(freq), 32'(vecs[0].exp_freq));
    check("b2b3 peak_mag", peak_mag, vecs[0].exp_peak);
    check("b2b3 overrun", 32'(overrun), 32'd0);
    check("b2b3 busy_drop", 32'(busy), 32'd0);

    // Overrun: second strobe 5 cycles after capture is dropped
    run_vector(0, 1, 5);

    // Reset mid-scan at idx = 8, with fft_valid held during the reset edge
    run_vector(1, 0, 0);
    @(negedge clk);
    load_frame(2);
    fft_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fft_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst       = 1'b1;
    fft_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    fft_valid = 1'b0;
    check("midrst done", 32'(done), 32'd0);
    check("midrst freq", 32'(freq), 32'd0);
    check("midrst peak_mag", peak_mag, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0)
        check($sformatf("midrst quiet_k%0d", k), {30'd0, done, busy}, 32'd0);
    end
    checks++;
    run_vector(5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
